// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder.
//   DEFAULT_WIDTH : default operand/result width in bits (legal range 1..32)
//   state_t       : controller state encoding, also exported for debug
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Signal bundle between a requester and the bit-serial adder.
//   start              : request an add of operand_a + operand_b (sampled in IDLE only)
//   operand_a/b        : addends, captured on the accepting edge
//   busy               : high whenever the controller is not IDLE
//   done               : one-cycle pulse when sum/carry_out are complete
//   sum, carry_out     : (a + b) mod 2^WIDTH and the MSB carry; held until next accept
//   serial_bit         : sum bit produced on the most recent SHIFT edge (LSB first)
//   dbg_state          : current controller state, for observation only
// Handshake: start is a level request. The edge that sees start=1 while busy=0
// accepts the operands; the result is valid from the cycle done=1 onwards.
// start and the operands are ignored while busy=1.
interface serial_add_ctrl_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             serial_bit;
  state_t           dbg_state;

  // Requester side.
  modport master (
    output start, operand_a, operand_b,
    input  busy, done, sum, carry_out, serial_bit, dbg_state
  );

  // Adder side.
  modport slave (
    input  start, operand_a, operand_b,
    output busy, done, sum, carry_out, serial_bit, dbg_state
  );

endinterface

// File: rtl/serial_fa_cell.sv
// One-bit serial full-adder cell: combinational sum bit plus the carry register.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   a, b         : current operand bits
//   clear        : zero the carry (start of a new operation)
//   enable       : advance the carry by one bit position
//   s            : a ^ b ^ carry
//   carry        : registered carry
module serial_fa_cell (
  input  logic clock,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic clear,
  input  logic enable,
  output logic s,
  output logic carry
);

  logic carry_next;

  always_comb begin
    s          = a ^ b ^ carry;
    carry_next = (a & b) | (a & carry) | (b & carry);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      carry <= 1'b0;
    end else if (clear) begin
      carry <= 1'b0;
    end else if (enable) begin
      carry <= carry_next;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts two WIDTH-bit operands, adds them one
// bit per cycle LSB first, and reports the result with a one-cycle done pulse.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : serial_add_ctrl_if slave modport (start/operands in,
//                  busy/done/sum/carry_out/serial_bit/dbg_state out)
// Timing: accept on E0, SHIFT edges E1..E_WIDTH, done high in the cycle after
// E_WIDTH, back to IDLE on the following edge (busy high WIDTH+1 cycles).
module serial_add_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH  // 1..32
) (
  input logic           clock,
  input logic           reset,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic [CNT_W-1:0] cnt_q;
  logic             serial_q;
  logic             fa_s, fa_carry;
  logic             accept, shift_en, last_bit;

  always_comb begin
    accept   = (state_q == IDLE) && bus.start;
    shift_en = (state_q == SHIFT);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  serial_fa_cell u_fa (
    .clock  (clock),
    .reset  (reset),
    .a      (a_q[0]),
    .b      (b_q[0]),
    .clear  (accept),
    .enable (shift_en),
    .s      (fa_s),
    .carry  (fa_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_s;
    end else begin : g_res_wn
      assign res_next = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand shifters, result register, bit counter, serial tap.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.operand_a;
      b_q   <= bus.operand_b;
      cnt_q <= '0;
    end else if (shift_en) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      res_q    <= res_next;
      serial_q <= fa_s;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);
    bus.sum        = res_q;
    bus.carry_out  = fa_carry;
    bus.serial_bit = serial_q;
    bus.dbg_state  = state_q;
  end

endmodule
